// File: rtl/led_blink.sv
// Four-channel free-running LED blinker.
// Each channel toggles its LED every COUNT_k clock cycles.
module led_blink #(
   parameter logic [31:0] g_COUNT_10HZ = 32'd1250000,
   parameter logic [31:0] g_COUNT_5HZ  = 32'd2500000,
   parameter logic [31:0] g_COUNT_2HZ  = 32'd6250000,
   parameter logic [31:0] g_COUNT_1HZ  = 32'd12500000
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   output logic o_LED_1,
   output logic o_LED_2,
   output logic o_LED_3,
   output logic o_LED_4
);

   localparam logic [31:0] COUNT [4] = '{
      g_COUNT_10HZ, g_COUNT_5HZ, g_COUNT_2HZ, g_COUNT_1HZ
   };

   logic [3:0] led;

   for (genvar k = 0; k < 4; k++) begin : g_ch
      logic [31:0] cnt;
      logic        tog;

      // COUNT=1 leaves the compare at 0, so tog flips every edge
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
         if (!i_Rst_L) begin
            cnt <= '0;
            tog <= 1'b0;
         end else if (cnt < COUNT[k] - 32'd1) begin
            cnt <= cnt + 32'd1;
         end else begin
            cnt <= '0;
            tog <= ~tog;
         end
      end

      assign led[k] = tog;
   end

   assign o_LED_1 = led[0];
   assign o_LED_2 = led[1];
   assign o_LED_3 = led[2];
   assign o_LED_4 = led[3];

endmodule

// File: tb/tb_led_blink.sv
// Self-checking bench for led_blink: table vectors, width tracking,
// and random async-reset pulses against an arithmetic reference.
`timescale 1ns/1ps
module tb_led_blink;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [3:0] led [3];
   int n = 0;
   int tests = 0;
   int fails = 0;

   // dut 0: 5/10/25/50, dut 1: 1/10/25/50, dut 2: defaults
   longint cfg [3][4];
   logic   prev [3][4];
   int     last [3][4];
   int     tcnt [3][4];

   led_blink #(
      .g_COUNT_10HZ(32'd5), .g_COUNT_5HZ(32'd10),
      .g_COUNT_2HZ(32'd25), .g_COUNT_1HZ(32'd50)
   ) u_a (
      .i_Clk(clk), .i_Rst_L(rst_n),
      .o_LED_1(led[0][0]), .o_LED_2(led[0][1]),
      .o_LED_3(led[0][2]), .o_LED_4(led[0][3])
   );

   led_blink #(
      .g_COUNT_10HZ(32'd1), .g_COUNT_5HZ(32'd10),
      .g_COUNT_2HZ(32'd25), .g_COUNT_1HZ(32'd50)
   ) u_b (
      .i_Clk(clk), .i_Rst_L(rst_n),
      .o_LED_1(led[1][0]), .o_LED_2(led[1][1]),
      .o_LED_3(led[1][2]), .o_LED_4(led[1][3])
   );

   led_blink u_c (
      .i_Clk(clk), .i_Rst_L(rst_n),
      .o_LED_1(led[2][0]), .o_LED_2(led[2][1]),
      .o_LED_3(led[2][2]), .o_LED_4(led[2][3])
   );

   // edges seen since the last reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) n <= 0;
      else        n <= n + 1;
   end

   typedef struct {
      int         edge_n;
      logic [3:0] leds;
      logic       b1;
   } vec_t;

   vec_t tbl [10];

   function automatic logic model(int e, longint c);
      return ((longint'(e) / c) % 2) == 1;
   endfunction

   task automatic chk(string nm, longint act, longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at n=%0d: got %0d expected %0d",
                  nm, n, act, exp);
      end
   endtask

   task automatic clr_track();
      for (int d = 0; d < 3; d++)
         for (int k = 0; k < 4; k++) begin
            prev[d][k] = 1'b0;
            last[d][k] = 0;
            tcnt[d][k] = 0;
         end
   endtask

   task automatic chk_zero(string nm);
      for (int d = 0; d < 3; d++)
         chk($sformatf("%s d%0d", nm, d), led[d], 0);
   endtask

   // one cycle: compare all LEDs with the model and check half-periods
   task automatic step();
      @(negedge clk);
      for (int d = 0; d < 3; d++)
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("model d%0d led%0d", d, k + 1),
                led[d][k], model(n, cfg[d][k]));
            if (led[d][k] !== prev[d][k]) begin
               chk($sformatf("width d%0d led%0d", d, k + 1),
                   n - last[d][k], cfg[d][k]);
               last[d][k] = n;
               tcnt[d][k]++;
               prev[d][k] = led[d][k];
            end
         end
   endtask

   task automatic run_to(int target);
      int g;
      g = 0;
      while (n < target && g < 2000) begin
         step();
         g++;
      end
      if (n != target) chk("run_to timeout", n, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int run, d, hold;
      cfg[0] = '{5, 10, 25, 50};
      cfg[1] = '{1, 10, 25, 50};
      cfg[2] = '{1250000, 2500000, 6250000, 12500000};
      tbl[0] = '{1,   4'b0000, 1'b1};
      tbl[1] = '{2,   4'b0000, 1'b0};
      tbl[2] = '{4,   4'b0000, 1'b0};
      tbl[3] = '{5,   4'b0001, 1'b1};
      tbl[4] = '{9,   4'b0001, 1'b1};
      tbl[5] = '{10,  4'b0010, 1'b0};
      tbl[6] = '{25,  4'b0101, 1'b1};
      tbl[7] = '{50,  4'b1010, 1'b0};
      tbl[8] = '{99,  4'b1111, 1'b1};
      tbl[9] = '{100, 4'b0000, 1'b0};
      clr_track();

      #1 rst_n = 1'b0;
      #1 chk_zero("async reset");
      repeat (10) begin
         @(negedge clk);
         chk_zero("reset hold");
      end
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_to(tbl[i].edge_n);
         chk($sformatf("tbl main n=%0d", tbl[i].edge_n),
             led[0], tbl[i].leds);
         chk($sformatf("tbl cnt1 n=%0d", tbl[i].edge_n),
             led[1][0], tbl[i].b1);
      end
      chk("toggles led1", tcnt[0][0], 20);
      chk("toggles led2", tcnt[0][1], 10);
      chk("toggles led3", tcnt[0][2], 4);
      chk("toggles led4", tcnt[0][3], 2);
      chk("toggles cnt1", tcnt[1][0], 100);
      chk("default led4 toggles", tcnt[2][3], 0);
      run_to(400);
      chk("toggles led1 400", tcnt[0][0], 80);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clr_track();
      run_to(37);
      #2 rst_n = 1'b0;
      #1 chk_zero("mid-run reset");
      @(negedge clk);
      chk_zero("mid-run hold");
      rst_n = 1'b1;
      clr_track();
      run_to(4);
      chk("post-reset led1 n=4", led[0][0], 0);
      run_to(5);
      chk("post-reset led1 n=5", led[0][0], 1);

      for (int r = 0; r < 12; r++) begin
         run = $urandom_range(150, 1);
         repeat (run) step();
         d = $urandom_range(3, 1);
         #(d) rst_n = 1'b0;
         #1 chk_zero("rand reset");
         clr_track();
         hold = $urandom_range(4, 1);
         repeat (hold) begin
            @(negedge clk);
            chk_zero("rand hold");
         end
         rst_n = 1'b1;
      end
      run_to(60);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
